bus_cycle_controller: RTL

BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

---
 rtl/bus_cycle_controller_if.sv | 31 +++
 rtl/bus_cycle_controller.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bus_cycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cycle_controller_if
//  Description : Sideband bundle between the bus cycle controller and the
//                rest of the system: stall request, phase/sync markers,
//                accumulator command, latched opcode, output port and pc.
//                master = controller side, slave = system side.
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_cycle_controller_if #(
    parameter int PC_WIDTH = 12
);
    logic                stall;               // freeze sequencer at next edge
    logic                sync;                // high during X3
    logic [2:0]          phase;               // A1=0 .. X3=7
    logic [1:0]          accumulator_enable;  // 00 idle, 01 load, 10 drive
    logic [7:0]          opcode;              // {OPR, OPA}
    logic [3:0]          port_out;            // written by WRP
    logic [PC_WIDTH-1:0] pc;                  // current program counter

    modport master (
        input  stall,
        output sync, phase, accumulator_enable, opcode, port_out, pc
    );

    modport slave (
        output stall,
        input  sync, phase, accumulator_enable, opcode, port_out, pc
    );
endinterface
`default_nettype wire

// File: rtl/bus_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cycle_controller
//  Description : 8-phase instruction-cycle sequencer on a shared 4-bit
//                tri-state bus. A1..A3 put the pc on the bus one nibble at a
//                time, M1/M2 fetch the opcode, X2 executes LDM (0xD?) or
//                WRP (0xE1), and X3 advances the pc.
//  Ports       : clk       - clock, rising edge active
//                reset_n   - asynchronous active-low reset
//                data_bus  - shared nibble bus (inout)
//                bus       - master modport of bus_cycle_controller_if
//  Revision    : 1.0  initial release
// ============================================================================
module bus_cycle_controller #(
    parameter int                  PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    inout  wire       [3:0]        data_bus,
    bus_cycle_controller_if.master bus
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    localparam logic [3:0] c_OPR_LDM = 4'hD;
    localparam logic [7:0] c_OP_WRP  = 8'hE1;

    phase_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [7:0]          r_opcode;
    logic [3:0]          r_port_out;
    logic [1:0]          r_acc_en;
    logic                r_sync;
    logic                r_drive;

    phase_t              w_next_state;
    logic                w_next_drive;
    logic [1:0]          w_next_acc_en;
    logic [11:0]         w_pc12;
    logic [3:0]          w_bus_val;

    // The phase encoding is a plain binary count, so X3 wraps to A1.
    assign w_next_state = phase_t'(r_state + 3'd1);

    // Registered outputs are precomputed from the state being entered. The
    // opcode is complete by the time X2 is entered (latched at end of M2).
    always_comb begin
        w_next_drive  = 1'b0;
        w_next_acc_en = 2'b00;
        case (w_next_state)
            PH_A1, PH_A2, PH_A3: w_next_drive = 1'b1;
            PH_X2: begin
                if (r_opcode[7:4] == c_OPR_LDM) begin
                    w_next_drive  = 1'b1;
                    w_next_acc_en = 2'b01;
                end else if (r_opcode == c_OP_WRP) begin
                    w_next_acc_en = 2'b10;
                end
            end
            default: ;
        endcase
    end

    // Address nibbles are taken from a 12-bit view of the pc so narrower or
    // wider pc widths still map onto the three address phases.
    assign w_pc12 = 12'(r_pc);

    always_comb begin
        w_bus_val = r_opcode[3:0];
        case (r_state)
            PH_A1:   w_bus_val = w_pc12[3:0];
            PH_A2:   w_bus_val = w_pc12[7:4];
            PH_A3:   w_bus_val = w_pc12[11:8];
            default: w_bus_val = r_opcode[3:0];
        endcase
    end

    // r_drive resets high so the pc appears in A1 the moment reset releases;
    // gating with reset_n keeps the bus floating while reset is held.
    assign data_bus = (reset_n && r_drive) ? w_bus_val : 4'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= PH_A1;
            r_pc       <= PC_RESET;
            r_opcode   <= 8'h00;
            r_port_out <= 4'h0;
            r_acc_en   <= 2'b00;
            r_sync     <= 1'b0;
            r_drive    <= 1'b1;
        end else if (!bus.stall) begin
            r_state  <= w_next_state;
            r_acc_en <= w_next_acc_en;
            r_drive  <= w_next_drive;
            r_sync   <= (w_next_state == PH_X3);
            case (r_state)
                PH_M1: r_opcode[7:4] <= data_bus;
                PH_M2: r_opcode[3:0] <= data_bus;
                PH_X2: begin
                    if (r_opcode == c_OP_WRP) begin
                        r_port_out <= data_bus;
                    end
                end
                PH_X3: r_pc <= r_pc + PC_WIDTH'(1);
                default: ;
            endcase
        end
    end

    assign bus.phase              = r_state;
    assign bus.sync               = r_sync;
    assign bus.accumulator_enable = r_acc_en;
    assign bus.opcode             = r_opcode;
    assign bus.port_out           = r_port_out;
    assign bus.pc                 = r_pc;

endmodule
`default_nettype wire
